rf_multiport: RTL and testbench

//   Parametrised register file: NRD combinational read ports and one write port.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_if.sv | 18 +
 rtl/rf_clear_seq.sv | 45 ++++
 rtl/rf_multiport.sv | 71 +++++++
 tb/tb_rf_multiport.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
// The state enum is shared by the clear sequencer; the address check is shared by the read and write paths.
package rf_pkg;

    typedef enum logic [0:0] {RF_CLEAR, RF_READY} rf_state_t;

    // True when addr names a real, writable/readable entry (not past the end, not the hard zero).
    function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth,
                                        input logic zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_if.sv
// Datapath-side bus of the register file: one write port, NRD packed read ports and busy.
interface rf_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
);

    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic                    busy;

    modport master (output we, waddr, wdata, raddr, input rdata, busy);
    modport slave  (input we, waddr, wdata, raddr, output rdata, busy);

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, zeroing it, then reports ready.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     busy_o,
    output logic                     clr_we_o,
    output logic [$clog2(DEPTH)-1:0] clr_addr_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                RF_CLEAR: begin
                    if (idx_q == LastIdx) begin
                        state_q <= RF_READY;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RF_READY: state_q <= RF_READY;
                default:  state_q <= RF_CLEAR;
            endcase
        end
    end

    // Reset counts as busy so that a write presented alongside reset is dropped.
    assign busy_o     = (state_q == RF_CLEAR) || reset_i;
    assign clr_we_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = idx_q;

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NRD combinational read ports, one write port, sequenced clear.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic clk,
    input logic reset,
    rf_if.slave bus
);

    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam logic        ZeroReg = (ZERO_REG != 0);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk_i      (clk),
        .reset_i    (reset),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign user_we  = !busy && bus.we && rf_addr_ok(32'(bus.waddr), DEPTH, ZeroReg);
    assign bus.busy = busy;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (user_we) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

        // Zero and out-of-range handling outrank forwarding.
        always_comb begin
            rd = '0;
            if (!busy && rf_addr_ok(32'(ra), DEPTH, ZeroReg)) begin
`ifdef RF_BYPASS_EN
                if (user_we && (bus.waddr == ra)) begin
                    rd = bus.wdata;
                end else begin
                    rd = mem_q[ra];
                end
`else
                rd = mem_q[ra];
`endif
            end
        end

        assign bus.rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a 32-deep hard-zero file and a 24-deep plain file driven in lockstep.
module tb_rf_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra [3];

    rf_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if0 ();
    rf_if #(.DATA_W(32), .ADDR_W(5), .NRD(3)) if1 ();

    assign if0.we    = we;
    assign if0.waddr = wa;
    assign if0.wdata = wd;
    assign if0.raddr = {ra[1], ra[0]};
    assign if1.we    = we;
    assign if1.waddr = wa;
    assign if1.wdata = wd;
    assign if1.raddr = {ra[2], ra[1], ra[0]};

    rf_multiport #(.DATA_W(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    rf_multiport #(.DATA_W(32), .DEPTH(24), .NRD(3), .ZERO_REG(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Reference model: contents plus remaining clear cycles per instance.
    logic [31:0] m0 [32];
    logic [31:0] m1 [24];
    int left0 = 0, left1 = 0;
    int busy_run0 = 0, busy_run1 = 0;
    int tests = 0, fails = 0;

    function automatic bit legal(input int d, input int a);
        int depth;
        bit zr;
        depth = (d != 0) ? 24 : 32;
        zr    = (d == 0);
        return (a < depth) && !(zr && a == 0);
    endfunction

    function automatic bit exp_busy(input int d);
        return reset || (((d != 0) ? left1 : left0) > 0);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input int a);
        if (exp_busy(d) || !legal(d, a)) return 32'h0;
`ifdef RF_BYPASS_EN
        if (we && int'(wa) == a && legal(d, int'(wa))) return wd;
`endif
        return (d != 0) ? m1[a] : m0[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [4:0] a_w, input logic [31:0] d_w,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        reset = r;
        we    = w;
        wa    = a_w;
        wd    = d_w;
        ra[0] = r0;
        ra[1] = r1;
        ra[2] = r2;
        #4;
        chk("busy0", {31'b0, if0.busy}, {31'b0, exp_busy(0)});
        chk("busy1", {31'b0, if1.busy}, {31'b0, exp_busy(1)});
        for (int k = 0; k < 2; k++)
            chk($sformatf("d0.rd%0d@%0d", k, ra[k]), if0.rdata[k*32 +: 32], exp_rd(0, int'(ra[k])));
        for (int k = 0; k < 3; k++)
            chk($sformatf("d1.rd%0d@%0d", k, ra[k]), if1.rdata[k*32 +: 32], exp_rd(1, int'(ra[k])));
        if (r) begin
            busy_run0 = 0;
            busy_run1 = 0;
        end else begin
            if (if0.busy === 1'b1) busy_run0++;
            if (if1.busy === 1'b1) busy_run1++;
        end
        @(posedge clk);
        if (r) begin
            foreach (m0[i]) m0[i] = '0;
            foreach (m1[i]) m1[i] = '0;
            left0 = 32;
            left1 = 24;
        end else begin
            if (left0 > 0) left0--;
            else if (w && legal(0, int'(a_w))) m0[a_w] = d_w;
            if (left1 > 0) left1--;
            else if (w && legal(1, int'(a_w))) m1[a_w] = d_w;
        end
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i += 3)
            step(0, 0, 5'd0, 32'h0, 5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32));
    endtask

    logic [4:0] a_rand;

    initial begin
        // Reset, then writes issued while busy must not land.
        step(1, 1, 5'd3, 32'hFFFF_0000, 5'd3, 5'd4, 5'd5);
        for (int i = 0; i < 32; i++)
            step(0, (i < 24), 5'(i), $urandom, 5'(i), 5'd5, 5'(i ^ 1));
        chk("busy_len0", busy_run0, 32);
        chk("busy_len1", busy_run1, 24);
        read_all();

        step(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        step(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        chk("deadbeef_p0", if0.rdata[31:0], 32'hDEAD_BEEF);
        chk("deadbeef_p1", if0.rdata[63:32], 32'hDEAD_BEEF);

        step(0, 1, 5'd0, 32'h1234, 5'd0, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("zero_reg1", if0.rdata[31:0], 32'h0);
        chk("zero_reg0", if1.rdata[31:0], 32'h1234);

        step(0, 1, 5'd30, 32'hAAAA, 5'd30, 5'd23, 5'd6);
        step(0, 0, 5'd0, 32'h0, 5'd30, 5'd23, 5'd6);
        chk("oor_read", if1.rdata[31:0], 32'h0);
        read_all();

        step(0, 1, 5'd7, 32'h55, 5'd7, 5'd7, 5'd7);
        step(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        chk("after_write7", if1.rdata[95:64], 32'h55);

        // Fill, start a second clear, and interrupt it at index 10.
        for (int i = 0; i < 40; i++)
            step(0, 1, 5'($urandom_range(0, 31)), $urandom, 5'(i % 32), 5'd7, 5'd5);
        step(1, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 10; i++)
            step(0, 1, 5'(i + 1), 32'hBAD0_0000 | i, 5'(i), 5'd5, 5'd7);
        step(1, 1, 5'd9, 32'hBAD1, 5'd9, 5'd10, 5'd11);
        for (int i = 0; i < 32; i++)
            step(0, 0, 5'd0, 32'h0, 5'(i), 5'd5, 5'd7);
        chk("restart_len0", busy_run0, 32);
        chk("restart_len1", busy_run1, 24);
        read_all();

        for (int i = 0; i < 400; i++) begin
            a_rand = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), a_rand, $urandom,
                 ($urandom_range(0, 2) == 0) ? a_rand : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? a_rand : 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
